// File: rtl/fpu_result_collector_if.sv
// Handshake bundle between the FPU operator sequencer, the result collector and the downstream consumer.
// The master modport is the sequencer/consumer side; the slave modport is the collector.
interface fpu_result_collector_if #(
  parameter int W     = 32,
  parameter int DEPTH = 4
);
  logic                     add_vld;
  logic                     mul_vld;
  logic                     sub_vld;
  logic                     fi;
  logic [W-1:0]             add_res;
  logic [W-1:0]             mul_res;
  logic [W-1:0]             sub_res;
  logic [W-1:0]             out_data;
  logic [1:0]               out_op;
  logic                     out_vld;
  logic                     out_rdy;
  logic                     round_done;
  logic                     seq_err;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output add_vld, mul_vld, sub_vld, fi, add_res, mul_res, sub_res, out_rdy,
    input  out_data, out_op, out_vld, round_done, seq_err, count
  );

  modport slave (
    input  add_vld, mul_vld, sub_vld, fi, add_res, mul_res, sub_res, out_rdy,
    output out_data, out_op, out_vld, round_done, seq_err, count
  );
endinterface

// File: rtl/fpu_result_collector.sv
// Captures add/mul/sub results into per-op holding registers, funnels them through a small FIFO
// to a valid/ready consumer, and checks each round for add->mul->sub->fi capture order.
//
// state    | meaning
// WAIT_ADD | round open, expecting the add result
// WAIT_MUL | add captured, expecting the mul result
// WAIT_SUB | mul captured, expecting the sub result
// WAIT_FI  | all three captured, expecting the end-of-round strobe
module fpu_result_collector #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  fpu_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] WAIT_ADD = 2'd0;
  localparam logic [1:0] WAIT_MUL = 2'd1;
  localparam logic [1:0] WAIT_SUB = 2'd2;
  localparam logic [1:0] WAIT_FI  = 2'd3;

  logic [2:0]    strb;
  logic [W-1:0]  res [3];
  logic [2:0]    hold_vld_q, hold_vld_d;
  logic [W-1:0]  hold_data_q [3];
  logic [W-1:0]  hold_data_d [3];

  logic [W-1:0]  mem_data_q [DEPTH];
  logic [1:0]    mem_op_q   [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    state_q, state_d, eff_state;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          pop, can_push, push;
  logic [2:0]    push_oh, push_clr;
  logic [1:0]    push_op;
  logic [W-1:0]  push_data;
  logic [2:0]    exp_oh;
  logic          good, order_err, fi_err, ovf;

  assign strb   = {bus.sub_vld, bus.mul_vld, bus.add_vld};
  assign res[0] = bus.add_res;
  assign res[1] = bus.mul_res;
  assign res[2] = bus.sub_res;

  assign pop      = (count_q != '0) && bus.out_rdy;
  assign can_push = (count_q != CW'(DEPTH)) || pop;

  // Fixed priority add > mul > sub; only entries captured on an earlier edge are eligible.
  always_comb begin
    push_oh   = 3'b000;
    push_op   = 2'd0;
    push_data = hold_data_q[0];
    if (hold_vld_q[0]) begin
      push_oh   = 3'b001;
      push_op   = 2'd0;
      push_data = hold_data_q[0];
    end else if (hold_vld_q[1]) begin
      push_oh   = 3'b010;
      push_op   = 2'd1;
      push_data = hold_data_q[1];
    end else if (hold_vld_q[2]) begin
      push_oh   = 3'b100;
      push_op   = 2'd2;
      push_data = hold_data_q[2];
    end
  end

  assign push     = can_push && (hold_vld_q != 3'b000);
  assign push_clr = push ? push_oh : 3'b000;
  // An entry leaving for the FIFO this cycle frees its slot, so a same-op strobe is not an overflow.
  assign ovf      = |(strb & hold_vld_q & ~push_clr);

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      hold_vld_d[k]  = hold_vld_q[k];
      hold_data_d[k] = hold_data_q[k];
      if (strb[k]) begin
        hold_vld_d[k]  = 1'b1;
        hold_data_d[k] = res[k];
      end else if (push_clr[k]) begin
        hold_vld_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // A matching strobe advances first, so sub+fi together in WAIT_SUB closes the round.
  always_comb begin
    case (state_q)
      WAIT_ADD: exp_oh = 3'b001;
      WAIT_MUL: exp_oh = 3'b010;
      WAIT_SUB: exp_oh = 3'b100;
      default:  exp_oh = 3'b000;
    endcase
    good      = (strb != 3'b000) && (strb == exp_oh);
    order_err = (strb != 3'b000) && !good;
    eff_state = good ? state_q + 2'd1 : state_q;
    state_d   = eff_state;
    done_d    = 1'b0;
    fi_err    = 1'b0;
    if (bus.fi) begin
      state_d = WAIT_ADD;
      if (eff_state == WAIT_FI) done_d = 1'b1;
      else                      fi_err = 1'b1;
    end
    err_d = err_q | ovf | order_err | fi_err;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_vld_q <= 3'b000;
      for (int k = 0; k < 3; k++) hold_data_q[k] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_op_q[i]   <= 2'd0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= WAIT_ADD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      hold_vld_q <= hold_vld_d;
      for (int k = 0; k < 3; k++) hold_data_q[k] <= hold_data_d[k];
      if (push) begin
        mem_data_q[wptr_q] <= push_data;
        mem_op_q[wptr_q]   <= push_op;
        wptr_q             <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_data   = mem_data_q[rptr_q];
  assign bus.out_op     = mem_op_q[rptr_q];
  assign bus.out_vld    = (count_q != '0);
  assign bus.count      = count_q;
  assign bus.round_done = done_q;
  assign bus.seq_err    = err_q;
endmodule

// File: tb/tb_fpu_result_collector.sv
// Self-checking bench for fpu_result_collector: vector table, directed corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_fpu_result_collector;
  localparam int W = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic a, m, s, f, rdy;
    logic [31:0] ad, md, sd;
    int          e_cnt;
    logic        e_vld;
    logic [1:0]  e_op;
    logic [31:0] e_data;
    logic        e_rd, e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  fpu_result_collector_if #(.W(W), .DEPTH(DEPTH)) bus ();
  fpu_result_collector #(.W(W), .DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // reference model state
  ent_t        q[$];
  bit          h_full[3];
  logic [31:0] h_data[3];
  int          exp_idx;
  bit          m_err, m_rd;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, expv, $time);
    end
  endfunction

  function automatic void model(input logic r, a, m, s, f, rdy, input logic [31:0] ad, md, sd);
    bit          stb[3];
    logic [31:0] rv[3];
    bit          pop;
    int          pushed, nstb, which;
    ent_t        e;
    stb = '{a, m, s};
    rv  = '{ad, md, sd};
    if (!r) begin
      q.delete();
      h_full = '{0, 0, 0};
      exp_idx = 0;
      m_err = 0;
      m_rd = 0;
      return;
    end
    pop = (q.size() != 0) && rdy;
    pushed = -1;
    if (q.size() < DEPTH || pop)
      for (int k = 0; k < 3; k++)
        if (pushed < 0 && h_full[k]) pushed = k;
    if (pop) void'(q.pop_front());
    if (pushed >= 0) begin
      e.op = 2'(pushed);
      e.data = h_data[pushed];
      q.push_back(e);
      h_full[pushed] = 0;
    end
    nstb = 0;
    which = 0;
    for (int k = 0; k < 3; k++)
      if (stb[k]) begin
        if (h_full[k]) m_err = 1;
        h_full[k] = 1;
        h_data[k] = rv[k];
        nstb++;
        which = k;
      end
    if (nstb > 0) begin
      if (nstb == 1 && which == exp_idx) exp_idx++;
      else m_err = 1;
    end
    m_rd = 0;
    if (f) begin
      if (exp_idx == 3) m_rd = 1;
      else m_err = 1;
      exp_idx = 0;
    end
  endfunction

  task automatic step(input logic r, a, m, s, f, rdy, input logic [31:0] ad, md, sd);
    @(negedge clk);
    rst_n = r;
    bus.add_vld = a;  bus.mul_vld = m;  bus.sub_vld = s;  bus.fi = f;
    bus.add_res = ad; bus.mul_res = md; bus.sub_res = sd; bus.out_rdy = rdy;
    model(r, a, m, s, f, rdy, ad, md, sd);
    @(posedge clk);
    #1;
    chk("m_count", bus.count, q.size());
    chk("m_vld", bus.out_vld, q.size() != 0);
    if (q.size() != 0) begin
      chk("m_data", bus.out_data, q[0].data);
      chk("m_op", bus.out_op, q[0].op);
    end
    chk("m_round_done", bus.round_done, m_rd);
    chk("m_seq_err", bus.seq_err, m_err);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, rdy, 0, 0, 0);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl[5];
  ent_t got_q[$];
  ent_t exp_q[$];

  initial begin
    bus.add_vld = 0; bus.mul_vld = 0; bus.sub_vld = 0; bus.fi = 0;
    bus.add_res = 0; bus.mul_res = 0; bus.sub_res = 0; bus.out_rdy = 0;

    // reset held low with strobes active
    step(0, 1, 1, 1, 1, 1, 32'h1, 32'h2, 32'h3);
    step(0, 1, 0, 1, 0, 1, 32'h4, 32'h5, 32'h6);
    chk("rst_vld", bus.out_vld, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_err", bus.seq_err, 0);
    chk("rst_done", bus.round_done, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_op", bus.out_op, 0);

    // nominal round, out_rdy=1
    tbl[0] = '{1,0,0,0,1, 32'h3F800000,0,0,          0,0,2'd0,32'h0,       0,0};
    tbl[1] = '{0,1,0,0,1, 0,32'h40000000,0,          1,1,2'd0,32'h3F800000,0,0};
    tbl[2] = '{0,0,1,0,1, 0,0,32'h40400000,          1,1,2'd1,32'h40000000,0,0};
    tbl[3] = '{0,0,0,1,1, 0,0,0,                     1,1,2'd2,32'h40400000,1,0};
    tbl[4] = '{0,0,0,0,1, 0,0,0,                     0,0,2'd0,32'h0,       0,0};
    for (int i = 0; i < 5; i++) begin
      step(1, tbl[i].a, tbl[i].m, tbl[i].s, tbl[i].f, tbl[i].rdy, tbl[i].ad, tbl[i].md, tbl[i].sd);
      chk("tbl_count", bus.count, tbl[i].e_cnt);
      chk("tbl_vld", bus.out_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk("tbl_op", bus.out_op, tbl[i].e_op);
        chk("tbl_data", bus.out_data, tbl[i].e_data);
      end
      chk("tbl_done", bus.round_done, tbl[i].e_rd);
      chk("tbl_err", bus.seq_err, tbl[i].e_err);
    end

    // backpressure over two rounds, then drain (also push+pop at full)
    rst_cycles(1);
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      logic [31:0] base;
      base = 32'hA000_0000 + 32'(r * 16);
      step(1, 1, 0, 0, 0, 0, base + 1, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0, base + 2, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0, base + 3);
      step(1, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) exp_q.push_back('{op: 2'(k), data: base + 32'(k + 1)});
    end
    idle(0, 3);
    chk("bp_count_sat", bus.count, 4);
    chk("bp_err", bus.seq_err, 0);
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (bus.out_vld) got_q.push_back('{op: bus.out_op, data: bus.out_data});
      step(1, 0, 0, 0, 0, 1, 0, 0, 0);
      if (i == 0) chk("full_pushpop_count", bus.count, 4);
    end
    chk("bp_drain_n", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      chk("bp_drain_op", got_q[i].op, exp_q[i].op);
      chk("bp_drain_data", got_q[i].data, exp_q[i].data);
    end
    chk("bp_err_end", bus.seq_err, 0);

    // order error: mul before add
    rst_cycles(1);
    step(1, 0, 1, 0, 0, 1, 0, 32'hBEEF0001, 0);
    chk("ord_err", bus.seq_err, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ord_op", bus.out_op, 1);
    chk("ord_data", bus.out_data, 32'hBEEF0001);
    step(1, 1, 0, 0, 0, 1, 32'h11, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 32'h22, 0);
    step(1, 0, 0, 1, 0, 1, 0, 0, 32'h33);
    step(1, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("ord_round_done", bus.round_done, 1);
    idle(1, 3);

    // early fi after add only
    rst_cycles(1);
    step(1, 1, 0, 0, 0, 1, 32'h55, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("early_err", bus.seq_err, 1);
    chk("early_no_done", bus.round_done, 0);
    step(1, 1, 0, 0, 0, 1, 32'h66, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 32'h77, 0);
    step(1, 0, 0, 1, 1, 1, 0, 0, 32'h88);
    chk("early_sub_fi_done", bus.round_done, 1);
    idle(1, 4);

    // randomized segments: legal-ish rounds with gaps, and unconstrained strobes
    for (int seg = 0; seg < 24; seg++) begin
      int p;
      p = 0;
      rst_cycles(1);
      for (int c = 0; c < 120; c++) begin
        logic a, m, s, f, rdy;
        a = 0; m = 0; s = 0; f = 0;
        rdy = ($urandom_range(0, 9) < 6);
        if (seg % 2 == 0) begin
          if ($urandom_range(0, 2) == 0) begin
            case (p)
              0: a = 1;
              1: m = 1;
              2: s = 1;
              default: f = 1;
            endcase
            p = (p + 1) % 4;
          end
        end else begin
          a = ($urandom_range(0, 4) == 0);
          m = ($urandom_range(0, 4) == 0);
          s = ($urandom_range(0, 4) == 0);
          f = ($urandom_range(0, 7) == 0);
        end
        step(1, a, m, s, f, rdy, $urandom, $urandom, $urandom);
      end
      idle(1, 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
